multi_updown_shift_sum: RTL
===========================

Name: multi_updown_shift_sum

Overview:
- Parametrised successor to the two-counter shift-and-sum datapath.
- Holds NCH independent W-bit up/down counters. Each counter has its own direction, a synchronous load and a selectable wrap/saturate mode.
- Produces a registered result {A >> B, sum of all counters} with an overflow flag, through a one-deep valid/ready output stage.
- Sits between the control sequencer (enables, loads, operands) and downstream datapath consumers.

Parameters:
- W, 4, counter, operand and sum-field width (2..16)
- NCH, 2, number of counter channels (2..8)
- SW, W+$clog2(NCH), internal full-precision sum width (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  counter step enable
- up_down  in  NCH  per-channel direction: 1 = increment, 0 = decrement
- sat_mode  in  1  0 = wrap mod 2^W, 1 = saturate at 0 / 2^W-1
- ld  in  1  synchronous load of all counters
- ld_val  in  NCH*W  load values; channel i = ld_val[i*W +: W]
- cnt  out  NCH*W  current counter values, same packing as ld_val
- A  in  W  shift operand
- B  in  W  shift amount
- in_valid  in  1  request to capture a result
- in_ready  out  1  capture slot available
- out_valid  out  1  result register holds valid data
- out_ready  in  1  downstream accepts result
- out  out  2W  result: [2W-1:W] = shifted A, [W-1:0] = sum
- ovf  out  1  sum exceeded W bits

Behaviour:
- Reset (async assert, sync-safe deassert internally not required): all cnt = 0, out = 0, ovf = 0, out_valid = 0.
- Counters, per edge, by priority:
  - ld = 1: cnt[i] <= ld_val[i] for all i; en ignored that cycle.
  - else en = 1: cnt[i] steps by +1 if up_down[i] = 1, by -1 otherwise.
  - else: hold.
- Wrap mode: F+1 -> 0 and 0-1 -> F (W=4 values).
- Saturate mode: 2^W-1 with increment holds 2^W-1; 0 with decrement holds 0.
- sat_mode is sampled each step. Changing it does not alter the stored value.
- Sum: S = zero-extended sum of all NCH current (pre-edge) cnt values, computed at SW bits.
  - Sum field = S[W-1:0].
  - ovf = |S[SW-1:W].
- Shift: logical right shift, zero fill. If B >= W, field = 0. If B = 0, field = A.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture on in_valid && in_ready: out <= {shift, sum}, ovf <= flag, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Latency is 1 cycle. Full throughput of 1 result/cycle when out_ready is held high.
- Captured data reflects counter values before that edge's step/load. A capture and a step in the same cycle are both performed.
- While out_valid && !out_ready: out and ovf are stable and in_ready = 0.
- Reset mid-operation clears out_valid immediately. Any pending result is discarded.
- No X on any output after reset deasserts.

Test Plan:
- Reset mid-run: counters at {3,7}, out_valid = 1; pulse rst_n low -> cnt = 0, out_valid = 0, out = 0 asynchronously, before the next clk edge.
- Wrap: W=4, NCH=2, ld {ch1 = 0, ch0 = F}, then en = 1, up_down = 2'b01, sat_mode = 0 -> ch0 = 0, ch1 = F.
- Saturate: same load and up_down with sat_mode = 1 -> ch0 = F, ch1 = 0, unchanged over 3 further en cycles.
- Overflow and shift: cnt = {8, 9}, A = B (hex), B = 1, in_valid = 1, out_ready = 1 -> next cycle out = 8'h51, ovf = 1, out_valid = 1.
- Backpressure: out_ready = 0, in_valid high for 3 cycles -> first result held stable, in_ready = 0. Raise out_ready -> next capture the following edge, no loss or duplication.
- Shift edges: B = 4, A = F -> out[7:4] = 0. B = 0, A = 6 -> out[7:4] = 6. Also load and step in the same cycle -> load wins.

Source files
------------

// File: rtl/multi_updown_shift_sum.sv
// NCH up/down counters (load/wrap/saturate) feeding a {A>>B, sum} result register with overflow flag.
// Latency: one cycle from capture to out_valid; counters update on the same edge.
// Backpressure: one-deep output slot; in_ready drops while a result is held and out_ready is low.
module multi_updown_shift_sum #(
    parameter int W   = 4,
    parameter int NCH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   up_down,
    input  logic             sat_mode,
    input  logic             ld,
    input  logic [NCH*W-1:0] ld_val,
    output logic [NCH*W-1:0] cnt,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out,
    output logic             ovf
);

    localparam int SW = W + $clog2(NCH);

    logic [NCH*W-1:0] cnt_r;
    logic [NCH*W-1:0] cnt_nxt;
    logic [W-1:0]     cur;
    logic [SW-1:0]    sum;
    logic [W-1:0]     shf;
    logic [2*W-1:0]   out_r;
    logic             ovf_r;
    logic             out_valid_r;

    // Load beats step; saturation only blocks the step that would cross an end stop.
    always_comb begin
        cnt_nxt = cnt_r;
        cur     = '0;
        for (int i = 0; i < NCH; i++) begin
            cur = cnt_r[i*W +: W];
            if (ld) begin
                cnt_nxt[i*W +: W] = ld_val[i*W +: W];
            end else if (en) begin
                if (up_down[i]) begin
                    cnt_nxt[i*W +: W] = (sat_mode && (cur == {W{1'b1}})) ? cur : cur + 1'b1;
                end else begin
                    cnt_nxt[i*W +: W] = (sat_mode && (cur == '0)) ? cur : cur - 1'b1;
                end
            end
        end
    end

    // Sum is taken from the pre-edge counter values so it matches what cnt shows.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SW'(cnt_r[i*W +: W]);
        end
    end

    always_comb begin
        shf = '0;
        if (int'(B) < W) begin
            shf = A >> B;
        end
    end

    assign in_ready = !out_valid_r || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            out_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt;
            if (in_valid && in_ready) begin
                out_r       <= {shf, sum[W-1:0]};
                ovf_r       <= |sum[SW-1:W];
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign cnt       = cnt_r;
    assign out       = out_r;
    assign ovf       = ovf_r;
    assign out_valid = out_valid_r;

endmodule
